// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with double-buffered frame and anode dead time.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  update_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*DIGITS-1:0]       act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0]         act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]         act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  logic                      pend_v_q, pend_v_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      frame_q, frame_d;

  logic                      slot_end, wrap, dark;
  logic [DIGITS-1:0][3:0]    act_nib;
  logic [3:0]                nib;
  logic [DIGITS-1:0]         lz_mask;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  assign slot_end = en_i && (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);
  assign act_nib  = act_data_q;
  assign nib      = act_nib[idx_q];

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en_i) cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Pending captures any time; active only changes on the frame wrap so a frame never tears.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_v_d     = pend_v_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (update_i) begin
      pend_data_d  = data_i;
      pend_dp_d    = dp_i;
      pend_blank_d = blank_i;
      pend_v_d     = 1'b1;
    end
    if (wrap) begin
      pend_v_d = 1'b0;
      if (update_i) begin
        act_data_d  = data_i;
        act_dp_d    = dp_i;
        act_blank_d = blank_i;
      end else if (pend_v_q) begin
        act_data_d  = pend_data_q;
        act_dp_d    = pend_dp_q;
        act_blank_d = pend_blank_q;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic lead;
  always_comb begin
    lz_mask = '0;
    lead    = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (act_nib[k] == 4'h0) && !act_dp_q[k]) lz_mask[k] = 1'b1;
      else lead = 1'b0;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    dark    = !en_i || act_blank_q[idx_q] || lz_mask[idx_q];
    seg_d   = (dark ? 7'b0 : glyph(nib)) ^ {7{SEG_ACTIVE_LOW}};
    dp_d    = (dark ? 1'b0 : act_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    // First cycle of each slot keeps anodes off to hide segment transitions.
    an_d    = (en_i && (cnt_q != '0)) ? (DIGITS'(1) << idx_q) : '0;
    frame_d = wrap;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_q         <= SEG_ACTIVE_LOW;
      an_q         <= '0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits, built around the hex-to-7-segment glyph table (0-F, segment order a..g = bit 6..0). Holds a double-buffered frame of `DIGITS` hex nibbles, scans one digit per prescaler slot with a one-cycle anode dead time against ghosting, and applies new frames only at frame boundaries to avoid tearing. Sits between board-level numeric logic and the display pins.

## Interface
- `DIGITS`, 4, number of digits scanned; legal range 1..8.
- `PRESCALE`, 50000, clock cycles per digit slot; minimum 2.
- `SEG_ACTIVE_LOW`, 0, 1 inverts `seg_o` and `dp_o` at the output register; `an_o` is always active-high.
- `clk_i`  input  1  single clock; all state on rising edge.
- `rst_ni`  input  1  reset, synchronous, active-low.
- `en_i`  input  1  scan enable.
- `data_i`  input  4*DIGITS  nibble k drives digit k; digit 0 at bits [3:0].
- `dp_i`  input  DIGITS  decimal point per digit.
- `blank_i`  input  DIGITS  force digit dark (segments and dp off).
- `update_i`  input  1  one-cycle request to capture `data_i`/`dp_i`/`blank_i`.
- `seg_o`  output  7  segments a..g, bit 6 = a.
- `dp_o`  output  1  decimal point of active digit.
- `an_o`  output  DIGITS  one-hot digit select, bit k = digit k.
- `frame_o`  output  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Slot counter `cnt` counts 0..PRESCALE-1 while `en_i`=1, wraps to 0; holds when `en_i`=0.
- Digit index `idx` advances on the cycle where `cnt`=PRESCALE-1 and `en_i`=1; wraps DIGITS-1 -> 0. DIGITS=1: `idx` stays 0.
- Pending buffer: `update_i`=1 latches `data_i`, `dp_i`, `blank_i` into pending regs and sets `pend_v`. A later `update_i` before the boundary overwrites pending (last write wins).
- Active buffer loads from pending and clears `pend_v` on the wrap edge (idx DIGITS-1 -> 0). If `update_i` coincides with the wrap edge, active buffer loads `data_i`/`dp_i`/`blank_i` directly and `pend_v` is cleared.
- Glyph: nibble of active digit through the standard table (0 = 7'b1111110 ... F = 7'b1000111). Blanked digit: seg = 0, dp = 0 (before polarity inversion).
- `en_i`=0: `an_o`=0, segments/dp dark; pending capture still works; boundary loads do not occur.

## Timing
- All outputs registered; each reflects `cnt`/`idx`/active buffer of the previous cycle (1-cycle latency).
- Dead time: `an_o`=0 in the first cycle of every slot (registered from `cnt`=0); `an_o`=onehot(`idx`) for remaining PRESCALE-1 cycles. `seg_o`/`dp_o` already show the new digit during the dead cycle.
- `frame_o` high exactly one cycle, the cycle after the wrap edge; period DIGITS*PRESCALE cycles with `en_i`=1.
- New data visible on `seg_o` no earlier than the cycle after the next wrap edge; worst case DIGITS*PRESCALE+1 cycles after `update_i`.
- Reset (`rst_ni`=0 at an edge, including mid-scan): `cnt`=0, `idx`=0, active and pending buffers 0, `pend_v`=0, `an_o`=0, `frame_o`=0, `seg_o`/`dp_o` dark (0, or all-ones if SEG_ACTIVE_LOW=1). First `an_o` assertion two cycles after release with `en_i`=1.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking — scanning from digit DIGITS-1 downward, every digit whose active nibble is 0 and whose dp is 0 is blanked until the first non-zero or dp digit; digit 0 is never blanked by this rule. Explicit `blank_i` still applies.
- Undefined: all digits displayed as stored; no extra logic.

## Test plan
- Reset then `en_i`=1, PRESCALE=4, DIGITS=4, data 16'h1234 via `update_i` -> after first wrap, `an_o` 0001 shows 7'b0110011 (4), then 0010 "3", 0100 "2", 1000 "1"; `an_o`=0 first cycle of each slot; `frame_o` every 16 cycles.
- `update_i` with 16'hABCD mid-frame -> current frame unchanged; change appears only after wrap; back-to-back updates -> last wins.
- `update_i` on wrap edge cycle -> new data shown in digit 0 slot immediately following.
- `blank_i`=4'b0010, `dp_i`=4'b0001 -> digit 1 dark, digit 0 `dp_o`=1; SEG_ACTIVE_LOW=1 inverts `seg_o`/`dp_o` only.
- `en_i`=0 mid-slot -> `an_o`=0 next cycle, `cnt`/`idx` hold; re-enable resumes same slot. `rst_ni`=0 mid-scan -> all outputs reset values next cycle.
- With `SEG7_LZB_EN`, data 16'h0040 -> digits 3,2 dark, digit 1 "4", digit 0 "0"; 16'h0000 -> only digit 0 lit.
